// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory request
// handshake and loads the IF/ID register, honouring redirect > stall > advance.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_npc,
  input  logic        i_redirect,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_pc_if,
  output logic [31:0] o_pc_add4,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
  output logic        o_ifid_valid
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic [31:0] r_hold_buf;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic [31:0] w_pc_add4;
  logic [31:0] w_npc_aligned;

  // Masking rather than slicing keeps every npc bit in use while forcing word alignment.
  assign w_npc_aligned = i_npc & 32'hFFFF_FFFC;
  assign w_pc_add4     = r_pc + 32'd4;

  // pc_if never moves while a request is outstanding, so it is always the request address.
  assign o_imem_req   = !i_rst && (r_state != HOLD);
  assign o_imem_addr  = r_pc;
  assign o_pc_if      = r_pc;
  assign o_pc_add4    = w_pc_add4;
  assign o_ifid_instr = r_ifid_instr;
  assign o_ifid_pc4   = r_ifid_pc4;
  assign o_ifid_valid = r_ifid_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_pend_pc    <= 32'd0;
      r_hold_buf   <= 32'd0;
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (i_redirect) begin
            r_ifid_valid <= 1'b0;
            if (i_imem_ready) begin
              r_pc <= w_npc_aligned;
            end else begin
              r_pend_pc <= w_npc_aligned;
              r_state   <= DRAIN;
            end
          end else if (i_imem_ready) begin
            if (!i_stall) begin
              r_ifid_instr <= i_imem_rdata;
              r_ifid_pc4   <= w_pc_add4;
              r_ifid_valid <= 1'b1;
              r_pc         <= w_pc_add4;
            end else begin
              r_hold_buf <= i_imem_rdata;
              r_state    <= HOLD;
            end
          end else if (!i_stall) begin
            r_ifid_valid <= 1'b0;
          end
        end
        // The in-flight word is thrown away; a same-cycle redirect beats the pending target.
        DRAIN: begin
          r_ifid_valid <= 1'b0;
          if (i_redirect) begin
            r_pend_pc <= w_npc_aligned;
          end
          if (i_imem_ready) begin
            r_pc    <= i_redirect ? w_npc_aligned : r_pend_pc;
            r_state <= FETCH;
          end
        end
        HOLD: begin
          if (i_redirect) begin
            r_pc         <= w_npc_aligned;
            r_ifid_valid <= 1'b0;
            r_state      <= FETCH;
          end else if (!i_stall) begin
            r_ifid_instr <= r_hold_buf;
            r_ifid_pc4   <= w_pc_add4;
            r_ifid_valid <= 1'b1;
            r_pc         <= w_pc_add4;
            r_state      <= FETCH;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes expected IF/ID loads into a
// scoreboard queue, a monitor pops them whenever a fresh instruction appears.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        redirect;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemReady;
  logic [31:0] pcIf;
  logic [31:0] pcAdd4;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPc4;
  logic        ifidValid;

  int checks = 0;
  int failures = 0;
  logic [63:0] expQueue[$];

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_npc        (npc),
    .i_redirect   (redirect),
    .i_stall      (stall),
    .o_imem_req   (imemReq),
    .o_imem_addr  (imemAddr),
    .i_imem_rdata (imemRdata),
    .i_imem_ready (imemReady),
    .o_pc_if      (pcIf),
    .o_pc_add4    (pcAdd4),
    .o_ifid_instr (ifidInstr),
    .o_ifid_pc4   (ifidPc4),
    .o_ifid_valid (ifidValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instrFor(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle: check pre-edge outputs at the negedge, then drive this cycle's inputs.
  task automatic applyStimulus(input logic rd, input logic [31:0] target, input logic st,
                               input logic rdy, input logic [31:0] expAddr,
                               input logic expReq, input logic expValid, input logic pushExp);
    @(negedge clk);
    checkOutput("imem_addr", imemAddr, expAddr);
    checkOutput("imem_req", {31'd0, imemReq}, {31'd0, expReq});
    checkOutput("ifid_valid", {31'd0, ifidValid}, {31'd0, expValid});
    redirect  = rd;
    npc       = target;
    stall     = st;
    imemReady = rdy;
    imemRdata = rdy ? instrFor(expAddr) : 32'hDEAD_BEEF;
    if (pushExp) expQueue.push_back({instrFor(expAddr), expAddr + 32'd4});
  endtask

  // A valid IF/ID after an unstalled edge is always a freshly loaded instruction.
  always @(posedge clk) begin
    logic stallAtEdge;
    logic [63:0] expected;
    stallAtEdge = stall;
    #1;
    if (!rst && ifidValid && !stallAtEdge) begin
      if (expQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_ifid: got pc4 %h expected none", ifidPc4);
      end else begin
        expected = expQueue.pop_front();
        checkOutput("ifid_instr", ifidInstr, expected[63:32]);
        checkOutput("ifid_pc4", ifidPc4, expected[31:0]);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; npc = 32'd0; redirect = 1'b0; stall = 1'b0;
    imemReady = 1'b0; imemRdata = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req", {31'd0, imemReq}, 32'd0);
    checkOutput("rst_pc", pcIf, 32'h0000_3000);
    checkOutput("rst_valid", {31'd0, ifidValid}, 32'd0);
    checkOutput("rst_instr", ifidInstr, 32'd0);
    checkOutput("rst_pc4", ifidPc4, 32'd0);
    checkOutput("rst_pc_add4", pcAdd4, 32'h0000_3004);
    rst = 1'b0;

    // Streaming with zero-wait memory, then a redirect with ready.
    applyStimulus(0, 32'h0,    0, 1, 32'h3000, 1, 0, 1);
    applyStimulus(0, 32'h0,    0, 1, 32'h3004, 1, 1, 1);
    applyStimulus(0, 32'h0,    0, 1, 32'h3008, 1, 1, 1);
    applyStimulus(1, 32'h3040, 0, 1, 32'h300C, 1, 1, 0);
    applyStimulus(0, 32'h0,    0, 1, 32'h3040, 1, 0, 1);
    applyStimulus(0, 32'h0,    0, 1, 32'h3044, 1, 1, 1);
    applyStimulus(0, 32'h0,    0, 1, 32'h3048, 1, 1, 1);
    applyStimulus(1, 32'h3010, 0, 1, 32'h304C, 1, 1, 0);

    // Redirect while the request is outstanding: DRAIN ignores stall, drops the word.
    applyStimulus(1, 32'h3080, 0, 0, 32'h3010, 1, 0, 0);
    applyStimulus(0, 32'h0,    0, 0, 32'h3010, 1, 0, 0);
    applyStimulus(0, 32'h0,    1, 1, 32'h3010, 1, 0, 0);
    applyStimulus(0, 32'h0,    0, 1, 32'h3080, 1, 0, 1);

    // Wait states: bubble when not stalled, full hold when stalled.
    applyStimulus(0, 32'h0,    0, 0, 32'h3084, 1, 1, 0);
    applyStimulus(0, 32'h0,    1, 0, 32'h3084, 1, 0, 0);
    applyStimulus(0, 32'h0,    0, 1, 32'h3084, 1, 0, 1);

    // Misaligned redirect target, then a stall that buffers the word in HOLD.
    applyStimulus(1, 32'h3022, 0, 1, 32'h3088, 1, 1, 0);
    applyStimulus(0, 32'h0,    0, 1, 32'h3020, 1, 0, 1);
    applyStimulus(0, 32'h0,    1, 1, 32'h3024, 1, 1, 0);
    applyStimulus(0, 32'h0,    1, 0, 32'h3024, 0, 1, 0);
    applyStimulus(0, 32'h0,    1, 0, 32'h3024, 0, 1, 0);
    checkOutput("hold_ifid_pc4", ifidPc4, 32'h3024);
    checkOutput("hold_ifid_instr", ifidInstr, instrFor(32'h3020));
    applyStimulus(0, 32'h0,    0, 0, 32'h3024, 0, 1, 1);

    // HOLD abandoned by a redirect.
    applyStimulus(0, 32'h0,    1, 1, 32'h3028, 1, 1, 0);
    applyStimulus(1, 32'h3103, 1, 0, 32'h3028, 0, 1, 0);
    applyStimulus(0, 32'h0,    0, 1, 32'h3100, 1, 0, 1);

    // DRAIN completing on the same cycle as a second redirect.
    applyStimulus(1, 32'h3200, 0, 0, 32'h3104, 1, 1, 0);
    applyStimulus(1, 32'h3300, 0, 1, 32'h3104, 1, 0, 0);
    applyStimulus(0, 32'h0,    0, 1, 32'h3300, 1, 0, 1);
    applyStimulus(0, 32'h0,    0, 1, 32'h3304, 1, 1, 1);

    // Address wrap at the top of memory.
    applyStimulus(1, 32'hFFFF_FFFC, 0, 1, 32'h3308, 1, 1, 0);
    applyStimulus(0, 32'h0,    0, 1, 32'hFFFF_FFFC, 1, 0, 1);
    checkOutput("wrap_pc_add4", pcAdd4, 32'h0000_0000);

    // Asynchronous reset in the middle of DRAIN.
    applyStimulus(1, 32'h3040, 0, 0, 32'h0000_0000, 1, 1, 0);
    applyStimulus(0, 32'h0,    0, 0, 32'h0000_0000, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_req", {31'd0, imemReq}, 32'd0);
    checkOutput("async_pc", pcIf, 32'h0000_3000);
    checkOutput("async_valid", {31'd0, ifidValid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 32'h0,    0, 1, 32'h3000, 1, 0, 1);
    applyStimulus(0, 32'h0,    0, 0, 32'h3004, 1, 1, 0);
    @(posedge clk);
    #2;
    checkOutput("queue_empty", expQueue.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
